// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block geometry, SubBytes FSM states and
// the byte-index slicing helper used across the round stages.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } sub_bytes_state_t;

  // AES byte i lives at the MSB end: byte 0 = s[127:120], byte 15 = s[7:0].
  function automatic logic [AES_BYTE_W-1:0] aes_byte(
    input logic [AES_BLOCK_W-1:0] s,
    input logic [3:0]             idx
  );
    return s[AES_BLOCK_W - AES_BYTE_W*(int'(idx) + 1) +: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_i,
  output logic [AES_BYTE_W-1:0] out_o
);

  // Row r holds the substitutions for inputs 16r .. 16r+15, lowest index first.
  localparam logic [0:255][7:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX_T[in_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: LANES S-boxes substitute LANES bytes of the held state
// per cycle, so one block takes 16/LANES substitution beats.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_state,
  output logic                   busy
);

  localparam int BEATS = AES_NBYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES < 1 || (AES_NBYTES % LANES) != 0) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must divide 16");
  end

  sub_bytes_state_t             state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [AES_BLOCK_W-1:0]       data_q, data_d;
  logic                         out_valid_q, busy_q;
  logic [LANES-1:0][3:0]        lane_idx;
  logic [LANES-1:0][AES_BYTE_W-1:0] sb_in, sb_out;

  wire last_beat = (cnt_q == CNT_W'(BEATS - 1));

  // One S-box per lane, fed from the byte slice selected by the beat counter.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_idx[g] = 4'(int'(cnt_q) * LANES + g);
    assign sb_in[g]    = aes_byte(data_q, lane_idx[g]);
    sbox u_sbox (.in_i(sb_in[g]), .out_o(sb_out[g]));
  end

  // Merge this beat's substituted bytes back into the held state.
  always_comb begin
    data_d = data_q;
    for (int l = 0; l < LANES; l++)
      data_d[AES_BLOCK_W - AES_BYTE_W*(int'(lane_idx[l]) + 1) +: AES_BYTE_W] = sb_out[l];
  end

  // Control FSM with registered out_valid/busy; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          data_q  <= in_state;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SUB;
        end
        SUB: begin
          data_q <= data_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_beat) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready depends only on state and rst, never on in_valid or out_ready.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: LANES=4 instance checked every cycle against a
// cycle-count model with a GF(2^8) SubBytes reference; LANES=1/16 instances
// checked on a directed vector for latency and result.
module tb_sub_bytes_iter;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] ALL_FF   = {16{8'hff}};
  localparam logic [127:0] ALL_16   = 128'h16161616161616161616161616161616;
  localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;
  localparam int BEATS4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv4, or4, iv1, or1, iv16, or16;
  logic [127:0] is4, is1, is16;
  logic         ir4, ov4, bz4, ir1, ov1, bz1, ir16, ov16, bz16;
  logic [127:0] os4, os1, os16;

  sub_bytes_iter #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_state(is4),
    .out_valid(ov4), .out_ready(or4), .out_state(os4), .busy(bz4));
  sub_bytes_iter #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_state(is1),
    .out_valid(ov1), .out_ready(or1), .out_state(os1), .busy(bz1));
  sub_bytes_iter #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_state(is16),
    .out_valid(ov16), .out_ready(or16), .out_state(os16), .busy(bz16));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // ---------------- reference SubBytes from field arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sb_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);  // a^254 = a^-1, 0 -> 0
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb_ref(s[127-8*i -: 8]);
    return r;
  endfunction

  // ---------------- behavioural model of the LANES=4 instance ----------------
  int           m_left  = 0;     // substitution cycles still owed
  bit           m_done  = 1'b0;  // a result is being offered
  bit           m_zero  = 1'b1;  // held state is known cleared by reset
  logic [127:0] m_res   = '0;
  logic [127:0] exp_q[$];
  int           n_acc   = 0;
  int           n_abort = 0;
  int           n_out   = 0;
  bit           chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_left > 0 || m_done) n_abort++;
      m_left = 0; m_done = 1'b0; m_zero = 1'b1;
      exp_q.delete();
    end else if (m_done) begin
      if (or4) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (iv4) begin
      m_left = BEATS4; m_res = subbytes(is4); m_zero = 1'b0;
      exp_q.push_back(m_res);
      n_acc++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 128'(ir4), 128'(!rst && m_left == 0 && !m_done));
      chk("out_valid", 128'(ov4), 128'(m_done));
      chk("busy", 128'(bz4), 128'(m_left > 0 || m_done));
      if (m_done) chk("out_state", os4, m_res);
      else if (m_zero) chk("out_state_cleared", os4, '0);
    end
  end

  // Ordered scoreboard on completed handshakes: no drops, no duplicates.
  always @(negedge clk) begin
    if (chk_en && !rst && ov4 && or4) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_output: got %h want none", os4);
      end else begin
        chk("stream_order", os4, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send4(input logic [127:0] d);
    int n;
    @(negedge clk);
    is4 = d; iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got no in_ready want in_ready within 200 cycles");
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ov4 && lat < 100);
  endtask

  task automatic run_alt(input int w, input logic [127:0] d, input logic [127:0] exp,
                         input int exp_lat, input string nm);
    int lat;
    logic vld;
    logic [127:0] os;
    @(negedge clk);
    if (w == 1) begin iv1 = 1'b1; is1 = d; end else begin iv16 = 1'b1; is16 = d; end
    chk({nm, "_in_ready"}, 128'((w == 1) ? ir1 : ir16), 128'(1));
    @(posedge clk); #1;
    iv1 = 1'b0; iv16 = 1'b0;
    lat = 0; vld = 1'b0; os = '0;
    while (!vld && lat < 40) begin
      @(negedge clk); lat++;
      vld = (w == 1) ? ov1 : ov16;
      os  = (w == 1) ? os1 : os16;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, "_result"}, os, exp);
  endtask

  bit rand_done = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat, n, stray;
    logic [127:0] cap;
    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b1; is4 = '0;
    iv1 = 1'b0; or1 = 1'b1; is1 = '0;
    iv16 = 1'b0; or16 = 1'b1; is16 = '0;

    // Pin the reference model to hand-computed values.
    chk("model_sb00", 128'(sb_ref(8'h00)), 128'h63);
    chk("model_sb53", 128'(sb_ref(8'h53)), 128'hed);
    chk("model_fips", subbytes(FIPS_IN), FIPS_OUT);
    chk("model_seq", subbytes(SEQ_IN), SEQ_OUT);

    // Reset state.
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(ir4), '0);
    chk("rst_out_valid", 128'(ov4), '0);
    chk("rst_busy", 128'(bz4), '0);
    chk("rst_out_state", os4, '0);
    chk("rst_out_state_l1", os1, '0);
    chk("rst_out_state_l16", os16, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 128'(ir4), 128'(1));

    // FIPS-197 round-1 vector, LANES=4.
    send4(FIPS_IN);
    wait_valid4(lat);
    chk("fips_latency", 128'(lat), 128'(5));
    chk("fips_result", os4, FIPS_OUT);

    // LANES=1 and LANES=16 on the sequential-byte vector.
    run_alt(1, SEQ_IN, SEQ_OUT, 17, "lanes1");
    run_alt(16, SEQ_IN, SEQ_OUT, 2, "lanes16");

    // Back-pressure: DONE holds for 10 cycles.
    or4 = 1'b0;
    send4(128'h00112233445566778899aabbccddeeff);
    wait_valid4(lat);
    cap = os4;
    chk("bp_result", cap, subbytes(128'h00112233445566778899aabbccddeeff));
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(ov4), 128'(1));
      chk("bp_stable", os4, cap);
      chk("bp_in_ready", 128'(ir4), '0);
    end
    or4 = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 128'(ir4), 128'(1));

    // in_valid held through SUB with a different state.
    @(negedge clk);
    is4 = FIPS_IN; iv4 = 1'b1;
    @(posedge clk); #1;
    is4 = ALL_FF;
    wait_valid4(lat);
    chk("hold_first_result", os4, FIPS_OUT);
    @(negedge clk);
    chk("hold_idle_in_ready", 128'(ir4), 128'(1));
    @(posedge clk); #1;
    iv4 = 1'b0;
    wait_valid4(lat);
    chk("hold_second_latency", 128'(lat), 128'(5));
    chk("hold_second_result", os4, ALL_16);

    // Reset pulse mid-SUB discards the block.
    send4(FIPS_IN);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 128'(ov4), '0);
    chk("abort_busy", 128'(bz4), '0);
    chk("abort_out_state", os4, '0);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin @(negedge clk); if (ov4) stray++; end
    chk("abort_no_output", 128'(stray), '0);
    send4('0);
    wait_valid4(lat);
    chk("zero_result", os4, ALL_63);

    // Random stream with random back-pressure.
    fork
      while (!rand_done) begin @(posedge clk); #1; or4 = 1'($urandom_range(0, 1)); end
    join_none
    for (int k = 0; k < 8; k++) send4({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin @(negedge clk); n++; end
    rand_done = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b1;
    repeat (3) @(negedge clk);

    chk("queue_drained", 128'(exp_q.size()), '0);
    chk("outputs_vs_accepts", 128'(n_out), 128'(n_acc - n_abort));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
